// File: rtl/ff_sync_pkg.sv
// rtl/ff_sync_pkg.sv - shared constants and sizing helper for the ff_sync_filter block
package ff_sync_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;

  function automatic int unsigned filter_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ff_sync_filter_channel.sv
// rtl/ff_sync_filter_channel.sv - one channel's glitch filter, filtered level and edge strobes
// Edge flops are built only when FF_SYNC_FILTER_EDGE_EN is defined.
module ff_sync_filter_channel
  import ff_sync_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_s,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign o_level = i_s;
`ifdef FF_SYNC_FILTER_EDGE_EN
      // Level is the chain output itself, so remember last cycle's value to spot the change.
      logic r_prev;
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_prev <= RESET_BIT;
        else         r_prev <= i_s;
      end
      assign o_rise = i_s & ~r_prev;
      assign o_fall = ~i_s & r_prev;
`else
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
`endif
    end else begin : g_filter
      localparam int unsigned CW = filter_cnt_width(FILTER_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic          r_level;
      logic          w_match;
      logic          w_hit;
      logic          w_next;

      assign w_match = (i_s == r_level);
      assign w_hit   = (r_cnt == LAST);
      assign w_next  = (!w_match && w_hit) ? i_s : r_level;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_cnt   <= '0;
          r_level <= RESET_BIT;
        end else begin
          r_level <= w_next;
          if (w_match || w_hit) r_cnt <= '0;
          else                  r_cnt <= r_cnt + CW'(1);
        end
      end

      assign o_level = r_level;

`ifdef FF_SYNC_FILTER_EDGE_EN
      logic r_rise;
      logic r_fall;
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_rise <= w_next & ~r_level;
          r_fall <= ~w_next & r_level;
        end
      end
      assign o_rise = r_rise;
      assign o_fall = r_fall;
`else
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: rtl/ff_sync_filter.sv
// rtl/ff_sync_filter.sv - multi-channel synchronizer, glitch filter and edge detector
// Optional rise/fall strobe flops: define FF_SYNC_FILTER_EDGE_EN.
module ff_sync_filter
  import ff_sync_pkg::*;
#(
  parameter int unsigned       WIDTH         = 1,
  parameter int unsigned       EXTRA_STAGES  = 0,
  parameter int unsigned       FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_data,
  output logic [WIDTH-1:0] sync_data,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int SYNC_DEPTH = int'(SYNC_MIN_STAGES + EXTRA_STAGES);

`ifdef FF_SYNC_FILTER_EDGE_EN
  localparam bit NEED_CHANNELS = 1'b1;
`else
  localparam bit NEED_CHANNELS = (FILTER_CYCLES != 0);
`endif

  // Whole chain shares one attribute so every stage is kept as a synchronizer flop.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync [SYNC_DEPTH];
  logic [WIDTH-1:0] w_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_DEPTH; k++) r_sync[k] <= RESET_VALUE;
    end else begin
      r_sync[0] <= async_data;
      for (int k = 1; k < SYNC_DEPTH; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_DEPTH-1];

  generate
    if (NEED_CHANNELS) begin : g_channels
      for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
        ff_sync_filter_channel #(
          .FILTER_CYCLES (FILTER_CYCLES),
          .RESET_BIT     (RESET_VALUE[i])
        ) u_channel (
          .i_clk   (clk),
          .i_reset (reset),
          .i_s     (w_s[i]),
          .o_level (sync_data[i]),
          .o_rise  (rise[i]),
          .o_fall  (fall[i])
        );
      end
    end else begin : g_direct
      assign sync_data = w_s;
      assign rise      = '0;
      assign fall      = '0;
    end
  endgenerate

endmodule
